// File: rtl/inst_rom_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | inst_rom_loader_if : byte-load stream, CPU fetch port and status    |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
interface inst_rom_loader_if #(
  parameter int ADDR_W = 10
);
  logic              ld_valid_i;
  logic [7:0]        ld_byte_i;
  logic              ld_last_i;
  logic              ld_ready_o;
  logic              ce;
  logic [31:0]       addr;
  logic [31:0]       inst;
  logic              cpu_rst_n_o;
  logic              load_done_o;
  logic              err_o;
  logic [ADDR_W:0]   word_cnt_o;

  modport master (
    output ld_valid_i, ld_byte_i, ld_last_i, ce, addr,
    input  ld_ready_o, inst, cpu_rst_n_o, load_done_o, err_o, word_cnt_o
  );

  modport slave (
    input  ld_valid_i, ld_byte_i, ld_last_i, ce, addr,
    output ld_ready_o, inst, cpu_rst_n_o, load_done_o, err_o, word_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/inst_rom_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | inst_rom_loader : loads a big-endian byte stream into instruction   |
// | storage, then releases the CPU and serves same-cycle fetches.       |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
module inst_rom_loader #(
  parameter int ADDR_W = 10
) (
  input  logic               Clk,
  input  logic               Rst_n,
  inst_rom_loader_if.slave   bus
);

  localparam int               c_DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0]  c_LAST_IDX = (ADDR_W+1)'(c_DEPTH - 1);

  localparam logic [1:0] c_LOAD = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_ERR  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        r_byte_idx;
  logic [ADDR_W:0]   r_word_cnt;
  logic [23:0]       r_asm;
  logic [31:0]       r_mem [0:c_DEPTH-1];

  logic              w_ready;
  logic              w_xfer;
  logic              w_write;
  logic [31:0]       w_word;
  logic [ADDR_W-1:0] w_fetch_idx;
  logic              w_addr_in_range;
  logic              w_hit;
  logic              w_unused_addr_lsb;

  assign w_ready = (r_state == c_LOAD);
  assign w_xfer  = bus.ld_valid_i && w_ready;
  // A last byte flushes whatever partial word is pending, zero-filled below.
  assign w_write = w_xfer && ((r_byte_idx == 2'd3) || bus.ld_last_i);

  always_comb begin
    w_word = 32'h0;
    unique case (r_byte_idx)
      2'd0:    w_word = {bus.ld_byte_i, 24'h0};
      2'd1:    w_word = {r_asm[23:16], bus.ld_byte_i, 16'h0};
      2'd2:    w_word = {r_asm[23:8], bus.ld_byte_i, 8'h0};
      default: w_word = {r_asm, bus.ld_byte_i};
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= c_LOAD;
      r_byte_idx <= 2'd0;
      r_word_cnt <= '0;
      r_asm      <= 24'h0;
    end else if (w_xfer) begin
      if (w_write) begin
        r_word_cnt <= r_word_cnt + 1'b1;
        r_byte_idx <= 2'd0;
        r_asm      <= 24'h0;
      end else begin
        r_byte_idx <= r_byte_idx + 2'd1;
        r_asm      <= w_word[31:8];
      end
      if (bus.ld_last_i) begin
        r_state <= c_RUN;
      end else if (w_write && (r_word_cnt == c_LAST_IDX)) begin
        r_state <= c_ERR;
      end
    end
  end

  // Storage is deliberately not reset; the word count hides stale entries.
  always_ff @(posedge Clk) begin
    if (w_write) begin
      r_mem[r_word_cnt[ADDR_W-1:0]] <= w_word;
    end
  end

  assign w_fetch_idx       = bus.addr[ADDR_W+1:2];
  assign w_addr_in_range   = (bus.addr[31:ADDR_W+2] == '0);
  assign w_unused_addr_lsb = ^bus.addr[1:0];
  assign w_hit = bus.ce && (r_state == c_RUN) && w_addr_in_range &&
                 ({1'b0, w_fetch_idx} < r_word_cnt);

  assign bus.inst        = w_hit ? r_mem[w_fetch_idx] : 32'h0;
  assign bus.ld_ready_o  = w_ready;
  assign bus.cpu_rst_n_o = (r_state == c_RUN);
  assign bus.load_done_o = (r_state == c_RUN);
  assign bus.err_o       = (r_state == c_ERR);
  assign bus.word_cnt_o  = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_inst_rom_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_inst_rom_loader : directed self-checking bench for the loader    |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
module tb_inst_rom_loader;

  localparam int ADDR_W = 10;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  inst_rom_loader_if #(.ADDR_W(ADDR_W)) bus ();

  inst_rom_loader #(.ADDR_W(ADDR_W)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    @(negedge clk);
    bus.ld_valid_i = 1'b1;
    bus.ld_byte_i  = b;
    bus.ld_last_i  = last;
    @(posedge clk);
    #1;
    bus.ld_valid_i = 1'b0;
    bus.ld_last_i  = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic ce, input logic [31:0] a,
                       input logic [31:0] exp);
    @(negedge clk);
    bus.ce   = ce;
    bus.addr = a;
    #1;
    check(tag, 64'(bus.inst), 64'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.ld_valid_i = 1'b0;
    bus.ld_last_i  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.ld_valid_i = 1'b0;
    bus.ld_byte_i  = 8'h00;
    bus.ld_last_i  = 1'b0;
    bus.ce         = 1'b1;
    bus.addr       = 32'h0;

    // Reset state
    #12;
    check("rst_ready",     64'(bus.ld_ready_o),  64'd1);
    check("rst_cpu_rst_n", 64'(bus.cpu_rst_n_o), 64'd0);
    check("rst_done",      64'(bus.load_done_o), 64'd0);
    check("rst_err",       64'(bus.err_o),       64'd0);
    check("rst_word_cnt",  64'(bus.word_cnt_o),  64'd0);
    check("rst_inst",      64'(bus.inst),        64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two full words, last on final byte
    send_byte(8'h34, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h0A, 1'b0);
    send_byte(8'h34, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    check("pre_last_cpu_rst_n", 64'(bus.cpu_rst_n_o), 64'd0);
    send_byte(8'h0B, 1'b1);
    check("two_word_cnt",  64'(bus.word_cnt_o),  64'd2);
    check("two_done",      64'(bus.load_done_o), 64'd1);
    check("two_cpu_rst_n", 64'(bus.cpu_rst_n_o), 64'd1);
    check("two_ready",     64'(bus.ld_ready_o),  64'd0);
    fetch("two_fetch0",   1'b1, 32'h0,      32'h3401000A);
    fetch("two_fetch4",   1'b1, 32'h4,      32'h3402000B);
    fetch("two_fetch8",   1'b1, 32'h8,      32'h0);
    fetch("two_fetch6",   1'b1, 32'h6,      32'h3402000B);
    fetch("ce_low",       1'b0, 32'h0,      32'h0);
    fetch("above_range",  1'b1, 32'h1000,   32'h0);
    send_byte(8'hFF, 1'b0);
    check("run_ignores_valid", 64'(bus.word_cnt_o), 64'd2);

    // Two-byte partial word; stale word 1 must stay hidden
    do_reset();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b1);
    check("part_word_cnt",  64'(bus.word_cnt_o),  64'd1);
    check("part_cpu_rst_n", 64'(bus.cpu_rst_n_o), 64'd1);
    fetch("part_fetch0", 1'b1, 32'h0, 32'hAABB0000);
    fetch("part_stale4", 1'b1, 32'h4, 32'h0);

    // Three-byte partial word
    do_reset();
    send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0); send_byte(8'h56, 1'b1);
    check("part3_word_cnt", 64'(bus.word_cnt_o), 64'd1);
    fetch("part3_fetch0", 1'b1, 32'h0, 32'h12345600);

    // Eight bytes with random gaps and junk on the idle byte lane
    do_reset();
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        bus.ld_valid_i = 1'b0;
        bus.ld_byte_i  = 8'($urandom);
        bus.ld_last_i  = 1'($urandom);
      end
      send_byte(8'(i + 1), (i == 7));
    end
    check("gap_word_cnt", 64'(bus.word_cnt_o), 64'd2);
    fetch("gap_fetch0", 1'b1, 32'h0, 32'h01020304);
    fetch("gap_fetch4", 1'b1, 32'h4, 32'h05060708);

    // Reset asserted mid-load discards partial word
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(8'hE0 + 8'(i), 1'b0);
    check("mid_word_cnt", 64'(bus.word_cnt_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_word_cnt", 64'(bus.word_cnt_o), 64'd0);
    check("async_ready",    64'(bus.ld_ready_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b1);
    check("reload_word_cnt", 64'(bus.word_cnt_o), 64'd1);
    fetch("reload_fetch0", 1'b1, 32'h0, 32'h11223344);
    fetch("reload_fetch4", 1'b1, 32'h4, 32'h0);

    // Full storage with last on the final byte goes to RUN
    do_reset();
    for (int k = 0; k < 4096; k++) send_byte(8'(k), (k == 4095));
    check("full_word_cnt", 64'(bus.word_cnt_o),  64'd1024);
    check("full_done",     64'(bus.load_done_o), 64'd1);
    check("full_err",      64'(bus.err_o),       64'd0);
    fetch("full_fetch0",   1'b1, 32'h0,   32'h00010203);
    fetch("full_fetchtop", 1'b1, 32'hFFC, 32'hFCFDFEFF);

    // Overflow without last goes to ERR
    do_reset();
    for (int k = 0; k < 4095; k++) send_byte(8'(k), 1'b0);
    check("ovf_pre_err",   64'(bus.err_o),      64'd0);
    check("ovf_pre_ready", 64'(bus.ld_ready_o), 64'd1);
    check("ovf_pre_cnt",   64'(bus.word_cnt_o), 64'd1023);
    send_byte(8'hFF, 1'b0);
    check("ovf_err",       64'(bus.err_o),       64'd1);
    check("ovf_ready",     64'(bus.ld_ready_o),  64'd0);
    check("ovf_cpu_rst_n", 64'(bus.cpu_rst_n_o), 64'd0);
    check("ovf_done",      64'(bus.load_done_o), 64'd0);
    check("ovf_cnt",       64'(bus.word_cnt_o),  64'd1024);
    fetch("ovf_inst", 1'b1, 32'h0, 32'h0);
    send_byte(8'h55, 1'b1);
    check("ovf_stays_err", 64'(bus.err_o),      64'd1);
    check("ovf_cnt_hold",  64'(bus.word_cnt_o), 64'd1024);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
